// File: rtl/vote_pkg.sv
// Shared types and constants for the ballot collector and the downstream voter blocks.
package vote_pkg;

  localparam int unsigned NUM_VOTERS = 5;
  localparam int unsigned BALLOT_W   = 3;
  localparam int unsigned ID_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PRESENT
  } state_e;

  localparam logic [1:0] REJ_NONE = 2'b00;
  localparam logic [1:0] REJ_ID   = 2'b01;
  localparam logic [1:0] REJ_DUP  = 2'b10;
  localparam logic [1:0] REJ_FMT  = 2'b11;

endpackage

// File: rtl/ballot_check.sv
// Combinational ballot validator: slot range, duplicate and one-hot format checks in priority order.
module ballot_check
  import vote_pkg::*;
(
  input  logic [ID_W-1:0]       id,
  input  logic [BALLOT_W-1:0]   ballot,
  input  logic [NUM_VOTERS-1:0] seen,
  output logic                  accept,
  output logic [1:0]            reject_code
);

  logic id_bad;
  logic dup;
  logic multi_hot;

  always_comb begin
    id_bad = (id == '0) || (id > ID_W'(NUM_VOTERS));
    dup    = 1'b0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      if (id == ID_W'(i + 1) && seen[i]) dup = 1'b1;
    end
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    multi_hot = (ballot & (ballot - BALLOT_W'(1))) != '0;
  end

  always_comb begin
    accept      = 1'b0;
    reject_code = REJ_NONE;
    if (id_bad)         reject_code = REJ_ID;
    else if (dup)       reject_code = REJ_DUP;
    else if (multi_hot) reject_code = REJ_FMT;
    else                accept      = 1'b1;
  end

endmodule

// File: rtl/ballot_box.sv
// Sequential ballot collector: gathers up to five one-hot ballots per round and holds them
// for the majority voter until acknowledged.
module ballot_box
  import vote_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic                ballot_valid,
  output logic                ballot_ready,
  input  logic [ID_W-1:0]     ballot_id,
  input  logic [BALLOT_W-1:0] ballot,
  output logic                reject,
  output logic [1:0]          reject_code,
  output logic [2:0]          count,
  output logic                out_valid,
  input  logic                out_ack,
  output logic [BALLOT_W-1:0] vote1,
  output logic [BALLOT_W-1:0] vote2,
  output logic [BALLOT_W-1:0] vote3,
  output logic [BALLOT_W-1:0] vote4,
  output logic [BALLOT_W-1:0] vote5
);

  state_e                state_q, state_d;
  logic [2:0]            count_q, count_d;
  logic [NUM_VOTERS-1:0] seen_q, seen_d;
  logic [BALLOT_W-1:0]   votes_q [NUM_VOTERS];
  logic [BALLOT_W-1:0]   votes_d [NUM_VOTERS];
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  reject_q, reject_d;
  logic [1:0]            code_q, code_d;

  logic       hs;
  logic       chk_accept;
  logic [1:0] chk_code;

  ballot_check u_check (
    .id          (ballot_id),
    .ballot      (ballot),
    .seen        (seen_q),
    .accept      (chk_accept),
    .reject_code (chk_code)
  );

  assign hs = ballot_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    seen_d   = seen_q;
    votes_d  = votes_q;
    reject_d = 1'b0;
    code_d   = REJ_NONE;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_VOTERS; i++) votes_d[i] = '0;
          count_d = '0;
          seen_d  = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (hs) begin
          if (chk_accept) begin
            for (int i = 0; i < NUM_VOTERS; i++) begin
              if (ballot_id == ID_W'(i + 1)) begin
                votes_d[i] = ballot;
                seen_d[i]  = 1'b1;
              end
            end
            count_d = count_q + 3'd1;
          end else begin
            reject_d = 1'b1;
            code_d   = chk_code;
          end
        end
        // The handshake is folded in first so a ballot arriving with close is kept.
        if (close || count_d == 3'(NUM_VOTERS)) state_d = PRESENT;
      end
      PRESENT: begin
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == COLLECT);
    valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      seen_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      code_q   <= REJ_NONE;
      for (int i = 0; i < NUM_VOTERS; i++) votes_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      seen_q   <= seen_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
      code_q   <= code_d;
      for (int i = 0; i < NUM_VOTERS; i++) votes_q[i] <= votes_d[i];
    end
  end

  assign ballot_ready = ready_q;
  assign out_valid    = valid_q;
  assign reject       = reject_q;
  assign reject_code  = code_q;
  assign count        = count_q;
  assign vote1        = votes_q[0];
  assign vote2        = votes_q[1];
  assign vote3        = votes_q[2];
  assign vote4        = votes_q[3];
  assign vote5        = votes_q[4];

endmodule

// File: tb/tb_ballot_box.sv
// Randomized and directed bench for ballot_box against a round-level reference model.
module tb_ballot_box;

  logic       clk = 1'b0;
  logic       rst, start, close, ballot_valid, out_ack;
  logic       ballot_ready, reject, out_valid;
  logic [2:0] ballot_id, ballot, count;
  logic [1:0] reject_code;
  logic [2:0] vote1, vote2, vote3, vote4, vote5;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 collecting, 2 presenting.
  int m_state;
  int m_count;
  int m_votes [1:5];
  bit m_seen  [1:5];
  int m_rej;
  int m_code;

  always #5 clk = ~clk;

  ballot_box dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .close        (close),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .ballot_id    (ballot_id),
    .ballot       (ballot),
    .reject       (reject),
    .reject_code  (reject_code),
    .count        (count),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .vote1        (vote1),
    .vote2        (vote2),
    .vote3        (vote3),
    .vote4        (vote4),
    .vote5        (vote5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit cl, input bit v,
                            input int id, input int b, input bit ack);
    logic [2:0] bb;
    int code;
    bb   = b[2:0];
    code = 0;
    if (r) begin
      m_state = 0;
      m_count = 0;
      for (int i = 1; i <= 5; i++) begin
        m_votes[i] = 0;
        m_seen[i]  = 1'b0;
      end
    end else if (m_state == 0) begin
      if (st) begin
        m_count = 0;
        for (int i = 1; i <= 5; i++) begin
          m_votes[i] = 0;
          m_seen[i]  = 1'b0;
        end
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (v) begin
        if (id < 1 || id > 5)        code = 1;
        else if (m_seen[id])         code = 2;
        else if ($countones(bb) > 1) code = 3;
        if (code == 0) begin
          m_votes[id] = b;
          m_seen[id]  = 1'b1;
          m_count++;
        end
      end
      if (cl || m_count == 5) m_state = 2;
    end else begin
      if (ack) m_state = 0;
    end
    m_rej  = (code != 0) ? 1 : 0;
    m_code = code;
  endtask

  task automatic check_all();
    check_eq("ready", ballot_ready, (m_state == 1) ? 1 : 0);
    check_eq("out_valid", out_valid, (m_state == 2) ? 1 : 0);
    check_eq("reject", reject, m_rej);
    check_eq("reject_code", reject_code, m_code);
    check_eq("count", count, m_count);
    check_eq("vote1", vote1, m_votes[1]);
    check_eq("vote2", vote2, m_votes[2]);
    check_eq("vote3", vote3, m_votes[3]);
    check_eq("vote4", vote4, m_votes[4]);
    check_eq("vote5", vote5, m_votes[5]);
  endtask

  task automatic cyc(input bit r, input bit st, input bit cl, input bit v,
                     input int id, input int b, input bit ack);
    rst          = r;
    start        = st;
    close        = cl;
    ballot_valid = v;
    ballot_id    = id[2:0];
    ballot       = b[2:0];
    out_ack      = ack;
    model_step(r, st, cl, v, id, b, ack);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic vote(input int id, input int b);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, id, b, 1'b0);
  endtask

  initial begin
    int fr_b [5];
    fr_b = '{1, 2, 1, 4, 1};
    rst = 1'b1; start = 1'b0; close = 1'b0; ballot_valid = 1'b0;
    ballot_id = '0; ballot = '0; out_ack = 1'b0;
    m_state = 0; m_count = 0; m_rej = 0; m_code = 0;
    for (int i = 1; i <= 5; i++) begin
      m_votes[i] = 0;
      m_seen[i]  = 1'b0;
    end

    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check_eq("rst_ready", ballot_ready, 0);
    check_eq("rst_count", count, 0);

    // Full round
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    check_eq("fr_ready", ballot_ready, 1);
    for (int i = 0; i < 5; i++) vote(i + 1, fr_b[i]);
    check_eq("fr_out_valid", out_valid, 1);
    check_eq("fr_count", count, 5);
    check_eq("fr_votes", {vote1, vote2, vote3, vote4, vote5}, 15'b001_010_001_100_001);
    idle_cyc();
    check_eq("fr_hold", out_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    check_eq("fr_ack", out_valid, 0);
    check_eq("fr_held_count", count, 5);

    // Rejects
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    vote(0, 1);
    check_eq("rej_id0", {reject, reject_code}, 3'b101);
    vote(6, 1);
    check_eq("rej_id6", {reject, reject_code}, 3'b101);
    vote(2, 3);
    check_eq("rej_fmt", {reject, reject_code}, 3'b111);
    vote(1, 2);
    check_eq("acc_id1", reject, 0);
    vote(1, 2);
    check_eq("rej_dup", {reject, reject_code}, 3'b110);
    idle_cyc();
    check_eq("rej_pulse", reject, 0);
    check_eq("rej_count", count, 1);
    check_eq("rej_vote1", vote1, 3'b010);

    // Early close; ballot in the close cycle is kept
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    vote(3, 4);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5, 1, 1'b0);
    check_eq("ec_out_valid", out_valid, 1);
    check_eq("ec_count", count, 2);
    check_eq("ec_votes", {vote1, vote2, vote3, vote4, vote5}, 15'b000_000_100_000_001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);

    // Abstain and ignored controls
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    check_eq("ig_close_idle", ballot_ready, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    vote(4, 0);
    check_eq("abs_count", count, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    check_eq("ig_start_collect", count, 1);

    // Reset mid-round
    vote(1, 1);
    vote(2, 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check_eq("mr_count", count, 0);
    check_eq("mr_ready", ballot_ready, 0);
    check_eq("mr_votes", {vote1, vote2, vote3, vote4, vote5}, 15'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
